// File: rtl/turret_pkg.sv
// Shared constants and register map for the turret servo APB peripheral.
package turret_pkg;

  localparam int unsigned TS_CNT_W      = 21;
  localparam int unsigned TS_DEF_PERIOD = 2000000;
  localparam int unsigned TS_DEF_PULSE  = 150000;
  localparam int unsigned TS_MIN_PERIOD = 1000;

  localparam logic [7:0] OFS_CTRL    = 8'h00;
  localparam logic [7:0] OFS_PERIOD  = 8'h04;
  localparam logic [7:0] OFS_SLEW    = 8'h08;
  localparam logic [7:0] OFS_STATUS  = 8'h0C;
  localparam logic [7:0] OFS_TARGET  = 8'h10;
  localparam logic [7:0] OFS_CURRENT = 8'h20;

  typedef enum logic [1:0] {
    ACC_OK,
    ACC_UNMAPPED,
    ACC_READONLY,
    ACC_BADVAL
  } acc_e;

  function automatic logic [5:0] word_idx(input logic [7:0] ofs);
    return ofs[7:2];
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target/current pulse width, per-frame slew step and
// registered PWM compare against the shared period counter.
module servo_channel
  import turret_pkg::*;
#(
  parameter int unsigned CNT_W     = TS_CNT_W,
  parameter int unsigned DEF_PULSE = TS_DEF_PULSE
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_frame_end,
  input  logic             i_tgt_we,
  input  logic [CNT_W-1:0] i_tgt_wdata,
  input  logic [CNT_W-1:0] i_slew,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [CNT_W-1:0] o_target,
  output logic [CNT_W-1:0] o_current,
  output logic             o_busy,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_current;
  logic             r_pwm;
  logic [CNT_W-1:0] w_mag;
  logic [CNT_W-1:0] w_next;

  // Magnitude computed on the ordered pair so the subtraction never wraps.
  assign w_mag = (r_target >= r_current) ? (r_target - r_current)
                                         : (r_current - r_target);

  always_comb begin
    w_next = r_current;
    if (i_slew == '0 || w_mag <= i_slew) begin
      w_next = r_target;
    end else if (r_target > r_current) begin
      w_next = r_current + i_slew;
    end else begin
      w_next = r_current - i_slew;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_target  <= CNT_W'(DEF_PULSE);
      r_current <= CNT_W'(DEF_PULSE);
      r_pwm     <= 1'b0;
    end else begin
      if (i_tgt_we) begin
        r_target <= i_tgt_wdata;
      end
      if (i_frame_end) begin
        r_current <= w_next;
      end
      r_pwm <= i_en & (i_cnt < r_current);
    end
  end

  assign o_target  = r_target;
  assign o_current = r_current;
  assign o_busy    = (r_current != r_target);
  assign o_pwm     = r_pwm;

endmodule

// File: rtl/turret_servo_apb.sv
// APB3 slave generating per-channel servo PWM with frame-rate slew limiting
// and a frame interrupt.
module turret_servo_apb
  import turret_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned CNT_W      = TS_CNT_W,
  parameter int unsigned DEF_PERIOD = TS_DEF_PERIOD,
  parameter int unsigned DEF_PULSE  = TS_DEF_PULSE
)(
  input  logic           FAB_CLK,
  input  logic           FAB_RESET,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [7:0]     PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic [NCH-1:0] SERVO_PWM,
  output logic           FRAME_IRQ
);

  logic [5:0]       w_idx;
  logic [CNT_W-1:0] w_wval;
  logic             w_access;
  logic             w_we;
  acc_e             w_acc;
  logic [CNT_W-1:0] w_rval;
  logic             w_frame_end;
  logic             w_en_rise;
  logic             w_unused_bits;

  logic             r_en;
  logic             r_irq_en;
  logic             r_frame;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_slew;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_target  [NCH];
  logic [CNT_W-1:0] w_current [NCH];
  logic [NCH-1:0]   w_busy;
  logic [NCH-1:0]   w_tgt_we;

  assign w_idx         = PADDR[7:2];
  assign w_wval        = PWDATA[CNT_W-1:0];
  assign w_access      = PSEL & PENABLE;
  assign w_unused_bits = ^{PADDR[1:0], PWDATA[31:CNT_W]};

  always_comb begin
    w_acc  = ACC_OK;
    w_rval = '0;
    if (w_idx == word_idx(OFS_CTRL)) begin
      w_rval = CNT_W'({r_irq_en, r_en});
    end else if (w_idx == word_idx(OFS_PERIOD)) begin
      w_rval = r_period;
      if (PWRITE && w_wval < CNT_W'(TS_MIN_PERIOD)) begin
        w_acc = ACC_BADVAL;
      end
    end else if (w_idx == word_idx(OFS_SLEW)) begin
      w_rval = r_slew;
    end else if (w_idx == word_idx(OFS_STATUS)) begin
      w_rval = CNT_W'({|w_busy, r_frame});
    end else begin
      w_acc = ACC_UNMAPPED;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_idx == word_idx(OFS_TARGET) + 6'(i)) begin
          w_acc  = ACC_OK;
          w_rval = w_target[i];
        end
        if (w_idx == word_idx(OFS_CURRENT) + 6'(i)) begin
          w_acc  = PWRITE ? ACC_READONLY : ACC_OK;
          w_rval = w_current[i];
        end
      end
    end
  end

  assign w_we      = w_access & PWRITE & (w_acc == ACC_OK);
  assign PSLVERR   = w_access & (w_acc != ACC_OK);
  assign PRDATA    = (w_access && !PWRITE && w_acc == ACC_OK) ? 32'(w_rval) : '0;
  assign PREADY    = 1'b1;
  assign FRAME_IRQ = r_frame & r_irq_en;

  assign w_frame_end = r_en & (r_cnt == r_active - 1'b1);
  assign w_en_rise   = w_we & (w_idx == word_idx(OFS_CTRL)) & PWDATA[0] & ~r_en;

  // PERIOD only reaches the counter through r_active, so a new value is
  // picked up at enable or at a frame boundary, never mid-frame.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_frame  <= 1'b0;
      r_period <= CNT_W'(DEF_PERIOD);
      r_slew   <= '0;
      r_active <= CNT_W'(DEF_PERIOD);
      r_cnt    <= '0;
    end else begin
      if (w_we && w_idx == word_idx(OFS_CTRL)) begin
        r_en     <= PWDATA[0];
        r_irq_en <= PWDATA[1];
      end
      if (w_we && w_idx == word_idx(OFS_PERIOD)) begin
        r_period <= w_wval;
      end
      if (w_we && w_idx == word_idx(OFS_SLEW)) begin
        r_slew <= w_wval;
      end
      if (w_frame_end) begin
        r_frame <= 1'b1;
      end else if (w_we && w_idx == word_idx(OFS_STATUS) && PWDATA[0]) begin
        r_frame <= 1'b0;
      end
      if (w_frame_end || w_en_rise) begin
        r_active <= r_period;
      end
      if (!r_en || w_frame_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_tgt_we[g] = w_we & (w_idx == word_idx(OFS_TARGET) + 6'(g));

    servo_channel #(
      .CNT_W     (CNT_W),
      .DEF_PULSE (DEF_PULSE)
    ) u_ch (
      .i_clk       (FAB_CLK),
      .i_rst       (FAB_RESET),
      .i_en        (r_en),
      .i_frame_end (w_frame_end),
      .i_tgt_we    (w_tgt_we[g]),
      .i_tgt_wdata (w_wval),
      .i_slew      (r_slew),
      .i_cnt       (r_cnt),
      .o_target    (w_target[g]),
      .o_current   (w_current[g]),
      .o_busy      (w_busy[g]),
      .o_pwm       (SERVO_PWM[g])
    );
  end

endmodule

// File: tb/tb_turret_servo_apb.sv
// Self-checking bench for turret_servo_apb: register table, PWM shape, IRQ and
// PERIOD timing, async reset, and randomized slew against a reference model.
module tb_turret_servo_apb;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [NCH-1:0] pwm;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  turret_servo_apb #(
    .NCH        (NCH),
    .CNT_W      (21),
    .DEF_PERIOD (2000000),
    .DEF_PULSE  (150000)
  ) dut (
    .FAB_CLK   (clk),
    .FAB_RESET (rst),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PADDR     (paddr),
    .PWDATA    (pwdata),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr),
    .SERVO_PWM (pwm),
    .FRAME_IRQ (irq)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ee, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.exp_rd = er; v.exp_err = ee; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Commit edge is the third rising edge after the call.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
    check({nm, " pslverr"}, {31'b0, e}, 32'd0);
  endtask

  task automatic rdchk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 32'd0, r, e);
    check({nm, " pslverr"}, {31'b0, e}, 32'd0);
    check(nm, r, exp);
  endtask

  task automatic wait_irq(input string nm, output int t);
    t = -1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: FRAME_IRQ not seen within 5000 cycles", nm);
    end
  endtask

  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    while (pwm[ch] === lvl && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic measure(input int ch, input int exp_hi, input int exp_lo);
    int n, lo, hi, lo2;
    run_len(ch, pwm[ch], n);
    if (pwm[ch] === 1'b1) run_len(ch, 1'b1, n);
    run_len(ch, 1'b0, lo);
    run_len(ch, 1'b1, hi);
    run_len(ch, 1'b0, lo2);
    check($sformatf("ch%0d low run", ch), lo, exp_lo);
    check($sformatf("ch%0d high run", ch), hi, exp_hi);
    check($sformatf("ch%0d low run repeat", ch), lo2, exp_lo);
  endtask

  function automatic int slew_step(input int cur, input int tgt, input int slew);
    int d;
    d = tgt - cur;
    if (slew == 0 || (d <= slew && d >= -slew)) return tgt;
    return (d > 0) ? cur + slew : cur - slew;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        err;
    int t, t0, t2, lim;
    int m_cur[NCH];
    int m_tgt[NCH];
    int m_slew, h0, h1;
    bit busy;

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset SERVO_PWM", {30'b0, pwm}, 32'd0);
    check("reset FRAME_IRQ", {31'b0, irq}, 32'd0);
    check("reset PSLVERR",   {31'b0, pslverr}, 32'd0);
    check("reset PRDATA",    prdata, 32'd0);
    check("PREADY",          {31'b0, pready}, 32'd1);

    tbl.push_back(mk(0, 8'h00, 0, 0,       0, "rst CTRL"));
    tbl.push_back(mk(0, 8'h04, 0, 2000000, 0, "rst PERIOD"));
    tbl.push_back(mk(0, 8'h08, 0, 0,       0, "rst SLEW"));
    tbl.push_back(mk(0, 8'h0C, 0, 0,       0, "rst STATUS"));
    tbl.push_back(mk(0, 8'h10, 0, 150000,  0, "rst TARGET0"));
    tbl.push_back(mk(0, 8'h14, 0, 150000,  0, "rst TARGET1"));
    tbl.push_back(mk(0, 8'h20, 0, 150000,  0, "rst CURRENT0"));
    tbl.push_back(mk(0, 8'h24, 0, 150000,  0, "rst CURRENT1"));
    tbl.push_back(mk(1, 8'h04, 999, 0,     1, "PERIOD=999"));
    tbl.push_back(mk(0, 8'h04, 0, 2000000, 0, "PERIOD unchanged"));
    tbl.push_back(mk(0, 8'h3C, 0, 0,       1, "read unmapped 0x3C"));
    tbl.push_back(mk(1, 8'h20, 77, 0,      1, "write CURRENT0"));
    tbl.push_back(mk(0, 8'h20, 0, 150000,  0, "CURRENT0 unchanged"));
    tbl.push_back(mk(1, 8'h18, 5, 0,       1, "write TARGET2 unmapped"));
    tbl.push_back(mk(0, 8'h28, 0, 0,       1, "read CURRENT2 unmapped"));
    tbl.push_back(mk(1, 8'h08, 32'hFFE0_0005, 0, 0, "SLEW upper bits"));
    tbl.push_back(mk(0, 8'h08, 0, 5,       0, "SLEW truncated"));
    tbl.push_back(mk(1, 8'h04, 1000, 0,    0, "PERIOD=1000"));
    tbl.push_back(mk(0, 8'h04, 0, 1000,    0, "PERIOD min accepted"));
    tbl.push_back(mk(1, 8'h0C, 0, 0,       0, "STATUS write 0"));

    foreach (tbl[i]) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err);
      check({tbl[i].name, " pslverr"}, {31'b0, err}, {31'b0, tbl[i].exp_err});
      if (!tbl[i].wr) check({tbl[i].name, " data"}, rd, tbl[i].exp_rd);
    end

    // PWM shape at PERIOD=2000
    wr("cfg PERIOD", 8'h04, 2000);
    wr("cfg TARGET0", 8'h10, 500);
    wr("cfg TARGET1", 8'h14, 1500);
    wr("cfg SLEW", 8'h08, 0);
    wr("cfg CTRL EN", 8'h00, 1);
    measure(0, 500, 1500);
    measure(1, 1500, 500);
    rdchk("CURRENT0 after ramp", 8'h20, 500);

    // IRQ, set-wins W1C and deferred PERIOD
    wr("CTRL EN+IRQ", 8'h00, 3);
    wr("clr0", 8'h0C, 1);
    wait_irq("sync irq", t);
    wr("clr1", 8'h0C, 1);
    wait_irq("irq rise", t0);
    wr("w1c", 8'h0C, 1);
    check("irq cleared by w1c", {31'b0, irq}, 32'd0);
    wr("PERIOD=3000 mid-frame", 8'h04, 3000);
    while (cyc < t0 + 1997) begin @(posedge clk); #1; end
    apb(1'b1, 8'h0C, 1, rd, err);
    check("w1c at frame end keeps irq", {31'b0, irq}, 32'd1);
    wr("w1c after set-wins", 8'h0C, 1);
    check("irq cleared again", {31'b0, irq}, 32'd0);
    wait_irq("irq after new period", t2);
    check("frame length after PERIOD write", t2 - (t0 + 2000), 3000);

    // async reset mid-pulse with IRQ pending
    lim = 0;
    while (pwm[1] !== 1'b1 && lim < 5000) begin @(posedge clk); #1; lim++; end
    check("ch1 high before reset", {31'b0, pwm[1]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset SERVO_PWM", {30'b0, pwm}, 32'd0);
    check("async reset FRAME_IRQ", {31'b0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rdchk("post-reset CTRL", 8'h00, 0);
    rdchk("post-reset PERIOD", 8'h04, 2000000);
    rdchk("post-reset CURRENT0", 8'h20, 150000);

    // slew ramp 150000 -> 150100 by 40
    wr("slew PERIOD", 8'h04, 1000);
    wr("slew SLEW", 8'h08, 40);
    wr("slew TARGET0", 8'h10, 150100);
    wr("slew CTRL", 8'h00, 3);
    for (int f = 0; f < 3; f++) begin
      wait_irq($sformatf("slew frame %0d", f), t);
      wr("slew clr", 8'h0C, 1);
      rdchk($sformatf("slew CURRENT0 f%0d", f), 8'h20, (f == 0) ? 150040 : (f == 1) ? 150080 : 150100);
      rdchk($sformatf("slew STATUS f%0d", f), 8'h0C, (f == 2) ? 0 : 2);
    end

    // randomized targets/slew against the reference model
    m_cur[0] = 150100; m_cur[1] = 150000;
    for (int trial = 0; trial < 3; trial++) begin
      for (int c = 0; c < NCH; c++) m_tgt[c] = $urandom_range(0, 1200);
      m_slew = (trial == 0) ? 0 : $urandom_range(150, 600);
      wr("rnd TARGET0", 8'h10, m_tgt[0]);
      wr("rnd TARGET1", 8'h14, m_tgt[1]);
      wr("rnd SLEW", 8'h08, m_slew);
      for (int f = 0; f < 20 && (m_cur[0] != m_tgt[0] || m_cur[1] != m_tgt[1]); f++) begin
        wait_irq("rnd frame", t);
        wr("rnd clr", 8'h0C, 1);
        busy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          m_cur[c] = slew_step(m_cur[c], m_tgt[c], m_slew);
          if (m_cur[c] != m_tgt[c]) busy = 1'b1;
        end
        rdchk("rnd CURRENT0", 8'h20, m_cur[0]);
        rdchk("rnd CURRENT1", 8'h24, m_cur[1]);
        rdchk("rnd STATUS", 8'h0C, {30'b0, busy, 1'b0});
      end
      h0 = 0; h1 = 0;
      for (int k = 0; k < 1000; k++) begin
        @(posedge clk); #1;
        h0 += int'(pwm[0]);
        h1 += int'(pwm[1]);
      end
      check("rnd ch0 high per frame", h0, (m_cur[0] < 1000) ? m_cur[0] : 1000);
      check("rnd ch1 high per frame", h1, (m_cur[1] < 1000) ? m_cur[1] : 1000);
      wr("rnd resync clr", 8'h0C, 1);
      wait_irq("rnd resync", t);
      wr("rnd resync clr2", 8'h0C, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
